// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide step sequencer: 74181 control
// codes, sequencer states and operation encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // 74181 codes: S select, M mode (1 = logic), active-low carry in
  localparam logic [3:0] ALU_S_ADD       = 4'b1001;
  localparam logic       ALU_M_ADD       = 1'b0;
  localparam logic       ALU_CIN_N_ADD   = 1'b1;
  localparam logic [3:0] ALU_S_SUB       = 4'b0110;
  localparam logic       ALU_M_SUB       = 1'b0;
  localparam logic       ALU_CIN_N_SUB   = 1'b0;
  localparam logic [3:0] ALU_S_PASSA     = 4'b1111;
  localparam logic       ALU_M_PASSA     = 1'b1;
  localparam logic       ALU_CIN_N_PASSA = 1'b1;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin_n;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD   = '{s: ALU_S_ADD,   m: ALU_M_ADD,   cin_n: ALU_CIN_N_ADD};
  localparam alu_ctrl_t ALU_SUB   = '{s: ALU_S_SUB,   m: ALU_M_SUB,   cin_n: ALU_CIN_N_SUB};
  localparam alu_ctrl_t ALU_PASSA = '{s: ALU_S_PASSA, m: ALU_M_PASSA, cin_n: ALU_CIN_N_PASSA};

endpackage

// File: rtl/mdstep_datapath.sv
// Accumulator/Q/divisor registers plus the per-step ALU operand mux and
// shift logic for shift-add multiply and restoring divide.
module mdstep_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             ld_dz,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout_n,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output alu_ctrl_t        alu_ctrl
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic [WIDTH-1:0] rem_shift;
  logic             carry;
  logic             accept;

  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    b_r_d     = b_r_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_PASSA;
    carry     = ~alu_cout_n;
    accept    = 1'b0;
    rem_shift = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
    if (ld) begin
      acc_d = '0;
      q_d   = opa;
      b_r_d = opb;
    end else if (ld_dz) begin
      acc_d = opa;
      q_d   = '1;
      b_r_d = opb;
    end else if (step) begin
      alu_b = b_r_q;
      if (is_div) begin
        // acc MSB set before the shift means the partial remainder already exceeds any divisor
        alu_a    = rem_shift;
        alu_ctrl = ALU_SUB;
        accept   = acc_q[WIDTH-1] | carry;
        acc_d    = accept ? alu_f : rem_shift;
        q_d      = {q_q[WIDTH-2:0], accept};
      end else begin
        alu_a = acc_q;
        if (q_q[0]) alu_ctrl = ALU_ADD;
        acc_d = {q_q[0] & carry, alu_f[WIDTH-1:1]};
        q_d   = {alu_f[0], q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      q_q   <= '0;
      b_r_q <= '0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      b_r_q <= b_r_d;
    end
  end

  assign acc = acc_q;
  assign q   = q_q;

endmodule

// File: rtl/alu_mdstep_seq.sv
// Multiply/divide step sequencer: FSM and step counter driving an external
// combinational 74181-style ALU through mdstep_datapath.
module alu_mdstep_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin_n,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout_n
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_r_q, op_r_d;
  logic          div_zero_q, div_zero_d;
  logic          ld, ld_dz, step;
  alu_ctrl_t     alu_ctrl;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_r_d     = op_r_q;
    div_zero_d = div_zero_q;
    ld         = 1'b0;
    ld_dz      = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          op_r_d = op;
          // zero divisor skips the step loop entirely
          if (op == OP_DIV && opb == '0) begin
            ld_dz      = 1'b1;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            ld         = 1'b1;
            div_zero_d = 1'b0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_r_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_r_q     <= op_r_d;
      div_zero_q <= div_zero_d;
    end
  end

  mdstep_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld),
    .ld_dz      (ld_dz),
    .step       (step),
    .is_div     (op_r_q),
    .opa        (opa),
    .opb        (opb),
    .alu_f      (alu_f),
    .alu_cout_n (alu_cout_n),
    .acc        (res_hi),
    .q          (res_lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl)
  );

  assign alu_s     = alu_ctrl.s;
  assign alu_m     = alu_ctrl.m;
  assign alu_cin_n = alu_ctrl.cin_n;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign div_zero  = div_zero_q;

endmodule
